// File: rtl/mem_access_unit.sv
// Memory-access stage between EX and WB: handshaked data-memory port with lane steering,
// load extension and misalignment flagging. Define MEM_TIMEOUT_EN to abort stalled accesses.
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [XLEN-1:0]    result,
  input  logic [XLEN-1:0]    data_store,
  input  logic [1:0]         whb,
  input  logic               su,
  input  logic [TAG_W-1:0]   tag,
  input  logic [XLEN-1:0]    pc_4,
  output logic               cs_d_n,
  output logic               rd,
  output logic               wr,
  output logic [XLEN-1:0]    d_addr,
  output logic [XLEN/8-1:0]  d_be,
  output logic [XLEN-1:0]    d_wdata,
  input  logic [XLEN-1:0]    d_rdata,
  input  logic               d_ack,
  output logic               out_valid,
  output logic [6:0]         out_opcode,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic [XLEN-1:0]    out_pc_4,
  output logic [XLEN-1:0]    out_ldata,
  output logic               out_misalign,
  output logic               out_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("mem_access_unit: XLEN must be 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [XLEN-1:0]  result;
    logic [1:0]       whb;
    logic             su;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  pc_4;
  } op_t;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  pc_4;
    logic [XLEN-1:0]  ldata;
    logic             misalign;
  } res_t;

  function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] lane,
                                                  input logic [1:0] sz, input logic zext);
    logic [XLEN-1:0] r;
    logic            msb;
    int              nbits;
    nbits = 8 << sz;
    if (nbits > XLEN) nbits = XLEN;
    case (sz)
      2'b00:   msb = lane[7];
      2'b01:   msb = lane[15];
      2'b10:   msb = lane[31];
      default: msb = lane[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? lane[i] : (msb & ~zext);
    return r;
  endfunction

  state_e          state_q, state_d;
  op_t             op_q, op_d;
  res_t            res_q, res_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic            in_mem, in_mis, accept, resp_entry, timeout;
  logic [OFF_W-1:0] in_off, op_off;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign in_mem     = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign in_off     = result[OFF_W-1:0];
  assign op_off     = op_q.result[OFF_W-1:0];
  assign resp_entry = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    case (whb)
      2'b00:   in_mis = 1'b0;
      2'b01:   in_mis = result[0];
      2'b10:   in_mis = |result[1:0];
      default: in_mis = (XLEN == 32) ? 1'b1 : |result[2:0];
    endcase
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = '{opcode: opcode, result: result, whb: whb, su: su, tag: tag, pc_4: pc_4};
          if (in_mem && !in_mis) begin
            state_d = ACCESS;
            addr_d  = {result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            be_d    = size_mask(whb) << in_off;
            wdata_d = data_store << (8 * in_off);
          end else begin
            state_d = RESP;
            res_d   = '{opcode: opcode, result: result, tag: tag, pc_4: pc_4,
                        ldata: '0, misalign: in_mem};
          end
        end
      end
      ACCESS: begin
        if (d_ack || timeout) begin
          state_d        = RESP;
          addr_d         = '0;
          be_d           = '0;
          wdata_d        = '0;
          res_d.opcode   = op_q.opcode;
          res_d.result   = op_q.result;
          res_d.tag      = op_q.tag;
          res_d.pc_4     = op_q.pc_4;
          res_d.misalign = 1'b0;
          // An ack in the timeout cycle still delivers its data.
          res_d.ldata    = (d_ack && op_q.opcode == OP_LOAD)
                         ? extend_load(d_rdata >> (8 * op_off), op_q.whb, op_q.su) : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_fault_q;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q != ACCESS) cnt_d = '0;
    else if (!d_ack) begin
      cnt_d   = cnt_q + CNT_W'(1);
      timeout = (cnt_d == CNT_W'(TIMEOUT_CYC));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      out_fault_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (resp_entry) out_fault_q <= timeout;
    end
  end
  assign out_fault = out_fault_q;
`else
  assign timeout   = 1'b0;
  assign out_fault = 1'b0;
`endif

  assign cs_d_n       = (state_q != ACCESS);
  assign rd           = (state_q == ACCESS) && (op_q.opcode == OP_LOAD);
  assign wr           = (state_q == ACCESS) && (op_q.opcode == OP_STORE);
  assign d_addr       = addr_q;
  assign d_be         = be_q;
  assign d_wdata      = wdata_q;
  assign out_valid    = (state_q == RESP);
  assign out_opcode   = res_q.opcode;
  assign out_result   = res_q.result;
  assign out_tag      = res_q.tag;
  assign out_pc_4     = res_q.pc_4;
  assign out_ldata    = res_q.ldata;
  assign out_misalign = res_q.misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32): loads, stores, misalignment, pass-through,
// mid-access reset, busy-input rejection, and the timeout path when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [6:0]        opcode;
  logic [XLEN-1:0]   result, data_store, pc_4;
  logic [1:0]        whb;
  logic              su;
  logic [TAG_W-1:0]  tag;
  logic              cs_d_n, rd, wr;
  logic [XLEN-1:0]   d_addr, d_wdata, d_rdata;
  logic [XLEN/8-1:0] d_be;
  logic              d_ack;
  logic              out_valid, out_misalign, out_fault;
  logic [6:0]        out_opcode;
  logic [XLEN-1:0]   out_result, out_pc_4, out_ldata;
  logic [TAG_W-1:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cyc;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .result(result), .data_store(data_store), .whb(whb), .su(su),
    .tag(tag), .pc_4(pc_4), .cs_d_n(cs_d_n), .rd(rd), .wr(wr), .d_addr(d_addr),
    .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_result(out_result),
    .out_tag(out_tag), .out_pc_4(out_pc_4), .out_ldata(out_ldata),
    .out_misalign(out_misalign), .out_fault(out_fault)
  );

  task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [XLEN-1:0] res, input logic [XLEN-1:0] ds,
                       input logic [1:0] sz, input logic zext, input logic [TAG_W-1:0] t,
                       input logic [XLEN-1:0] pc);
    opcode = op; result = res; data_store = ds; whb = sz; su = zext; tag = t; pc_4 = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = '0; result = '0; data_store = '0; whb = '0;
    su = 1'b0; tag = '0; pc_4 = '0; d_rdata = '0; d_ack = 1'b0;
    tick();
    tick();
    check("rst_cs_d_n", cs_d_n, 1);
    check("rst_rd", rd, 0);
    check("rst_wr", wr, 0);
    check("rst_d_addr", d_addr, 0);
    check("rst_d_be", d_be, 0);
    check("rst_d_wdata", d_wdata, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_fault", out_fault, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // lb, sign-extended, ack in the first ACCESS cycle
    issue(OP_LOAD, 32'h103, 32'h0, 2'b00, 1'b0, 5'd1, 32'h14);
    check("lb_cs_d_n", cs_d_n, 0);
    check("lb_rd", rd, 1);
    check("lb_wr", wr, 0);
    check("lb_d_addr", d_addr, 32'h100);
    check("lb_d_be", d_be, 4'b1000);
    check("lb_in_ready", in_ready, 0);
    check("lb_no_early_valid", out_valid, 0);
    d_rdata = 32'h80AA5500;
    d_ack   = 1'b1;
    tick();
    d_ack = 1'b0;
    check("lb_out_valid", out_valid, 1);
    check("lb_out_ldata", out_ldata, 32'hFFFFFF80);
    check("lb_out_tag", out_tag, 5'd1);
    check("lb_out_fault", out_fault, 0);
    check("lb_strobes_drop", cs_d_n, 1);
    tick();
    check("lb_valid_pulse", out_valid, 0);
    check("lb_in_ready_again", in_ready, 1);

    // sh with three wait states; an op offered while busy must be ignored
    issue(OP_STORE, 32'h202, 32'h0000BEEF, 2'b01, 1'b0, 5'd2, 32'h18);
    check("sh_d_be", d_be, 4'b1100);
    check("sh_d_wdata", d_wdata, 32'hBEEF0000);
    check("sh_d_addr", d_addr, 32'h200);
    check("sh_rd", rd, 0);
    strobe_cyc = int'(wr);
    opcode = OP_ADD; result = 32'h999; tag = 5'd7; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobe_cyc += int'(wr);
      check("sh_wdata_hold", d_wdata, 32'hBEEF0000);
    end
    in_valid = 1'b0;
    d_ack    = 1'b1;
    tick();
    d_ack = 1'b0;
    check("sh_wr_cycles", strobe_cyc, 4);
    check("sh_out_valid", out_valid, 1);
    check("sh_out_result", out_result, 32'h202);
    check("sh_out_tag", out_tag, 5'd2);
    check("sh_out_ldata", out_ldata, 0);
    check("sh_wr_drop", wr, 0);
    tick();
    tick();
    check("busy_op_ignored_valid", out_valid, 0);
    check("busy_op_ignored_tag", out_tag, 5'd2);

    // d_ack while idle must have no effect
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    check("idle_ack_valid", out_valid, 0);
    check("idle_ack_ready", in_ready, 1);

    // misaligned lw: no access, flagged the cycle after accept
    issue(OP_LOAD, 32'h101, 32'h0, 2'b10, 1'b0, 5'd3, 32'h1C);
    check("mis_out_valid", out_valid, 1);
    check("mis_out_misalign", out_misalign, 1);
    check("mis_out_ldata", out_ldata, 0);
    check("mis_cs_d_n", cs_d_n, 1);
    check("mis_rd", rd, 0);
    tick();

    // pass-through add
    issue(OP_ADD, 32'h1234, 32'h0, 2'b10, 1'b0, 5'd5, 32'h48);
    check("add_out_valid", out_valid, 1);
    check("add_out_result", out_result, 32'h1234);
    check("add_out_opcode", out_opcode, OP_ADD);
    check("add_out_pc_4", out_pc_4, 32'h48);
    check("add_out_tag", out_tag, 5'd5);
    check("add_out_misalign", out_misalign, 0);
    check("add_cs_d_n", cs_d_n, 1);
    tick();
    check("add_valid_pulse", out_valid, 0);
    check("add_result_hold", out_result, 32'h1234);

    // lh sign-extended from the upper half
    issue(OP_LOAD, 32'h6, 32'h0, 2'b01, 1'b0, 5'd6, 32'h4C);
    check("lh_d_addr", d_addr, 32'h4);
    check("lh_d_be", d_be, 4'b1100);
    d_rdata = 32'h9ABC0000;
    d_ack   = 1'b1;
    tick();
    d_ack = 1'b0;
    check("lh_out_ldata", out_ldata, 32'hFFFF9ABC);
    tick();

    // lhu with an asynchronous reset pulse mid-access, then a clean retry
    issue(OP_LOAD, 32'h2, 32'h0, 2'b01, 1'b1, 5'd9, 32'h50);
    check("lhu_rd", rd, 1);
    check("lhu_d_be", d_be, 4'b1100);
    #1 rst = 1'b1;
    #1;
    check("midrst_cs_d_n", cs_d_n, 1);
    check("midrst_rd", rd, 0);
    check("midrst_d_be", d_be, 0);
    check("midrst_out_result", out_result, 0);
    #1 rst = 1'b0;
    tick();
    check("midrst_no_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    issue(OP_LOAD, 32'h2, 32'h0, 2'b01, 1'b1, 5'd9, 32'h50);
    d_rdata = 32'h8001FFFF;
    d_ack   = 1'b1;
    tick();
    d_ack = 1'b0;
    check("lhu_out_valid", out_valid, 1);
    check("lhu_out_ldata", out_ldata, 32'h00008001);
    check("lhu_out_tag", out_tag, 5'd9);
    tick();

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after four ACCESS cycles with out_fault
    issue(OP_LOAD, 32'h300, 32'h0, 2'b10, 1'b0, 5'd11, 32'h54);
    strobe_cyc = int'(rd);
    opcode = OP_ADD; tag = 5'd12; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobe_cyc += int'(rd);
    end
    in_valid = 1'b0;
    tick();
    check("to_rd_cycles", strobe_cyc, 4);
    check("to_out_valid", out_valid, 1);
    check("to_out_fault", out_fault, 1);
    check("to_out_ldata", out_ldata, 0);
    check("to_rd_drop", rd, 0);
    check("to_out_tag", out_tag, 5'd11);
    tick();
    check("to_busy_ignored", out_valid, 0);
`endif

    check("final_out_fault_default", out_fault, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
